// File: rtl/huff_dec_ctrl.sv
// Huffman decoder job controller: loads the code table into the decoder, feeds coded bytes
// and counts decoded symbols to completion. Optional watchdog is enabled by HDC_TIMEOUT_EN.
module huff_dec_ctrl #(
    parameter int W  = 8,
    parameter int TW = 5,
    parameter int CW = 16
`ifdef HDC_TIMEOUT_EN
    ,
    parameter int TMO = 255
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [TW:0]   n_codes,
    input  logic [CW-1:0] n_bytes,
    input  logic [CW-1:0] n_syms,
    output logic [TW-1:0] tbl_addr,
    input  logic [W-1:0]  tbl_d,
    input  logic [W-1:0]  tbl_h,
    input  logic [W-1:0]  tbl_w,
    input  logic          src_valid,
    input  logic [W-1:0]  src_data,
    output logic          src_ready,
    output logic          dec_new_conf,
    output logic          dec_en_conf,
    output logic [W-1:0]  dec_d_conf,
    output logic [W-1:0]  dec_h_conf,
    output logic [W-1:0]  dec_w_conf,
    output logic          dec_ready_in,
    input  logic          dec_d_req,
    output logic [W-1:0]  dec_d_in,
    output logic          dec_en_in,
    input  logic          dec_en_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]    state_reg, state_next;
    logic [TW:0]   n_codes_reg;
    logic [CW-1:0] n_bytes_reg;
    logic [CW-1:0] n_syms_reg;
    logic [TW:0]   idx_reg;
    logic [CW-1:0] bytes_sent_reg;
    logic [CW-1:0] sym_cnt_reg;
    logic [W-1:0]  dec_d_in_reg;
    logic          dec_en_in_reg;

    logic          kill;
    logic          active;
    logic          hs;
    logic          last_byte;
    logic [CW-1:0] sym_inc;
    logic          sym_hit;
    logic          wdog_fire;

    // abort only matters once a job is running; in IDLE it is a no-op
    assign kill      = abort && (state_reg != IDLE);
    assign active    = (state_reg == RUN) || (state_reg == DRAIN);
    assign src_ready = (state_reg == RUN) && dec_d_req && (bytes_sent_reg < n_bytes_reg);
    assign hs        = src_valid && src_ready;
    assign last_byte = hs && ((bytes_sent_reg + CW'(1)) == n_bytes_reg);
    assign sym_inc   = (sym_cnt_reg == '1) ? sym_cnt_reg : sym_cnt_reg + CW'(1);
    assign sym_hit   = active && dec_en_out && (sym_inc >= n_syms_reg);

`ifdef HDC_TIMEOUT_EN
    localparam int TMW = $clog2(TMO + 1);

    logic [TMW-1:0] tmo_cnt_reg;
    logic           err_reg;

    assign wdog_fire = active && !dec_en_out && (tmo_cnt_reg == TMW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            if (!active || dec_en_out)
                tmo_cnt_reg <= '0;
            else if (!wdog_fire)
                tmo_cnt_reg <= tmo_cnt_reg + TMW'(1);
            if (state_reg == IDLE && start)
                err_reg <= 1'b0;
            else if (wdog_fire)
                err_reg <= 1'b1;
        end
    end

    assign err = (state_reg == DONE) && err_reg;
`else
    assign wdog_fire = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = CLEAR;
            CLEAR: begin
                if (n_codes_reg != '0)
                    state_next = LOAD;
                else if (n_syms_reg == '0)
                    state_next = DONE;
                else
                    state_next = RUN;
            end
            // LOAD runs one extra cycle so the last ROM word is presented while still in LOAD
            LOAD:  if (idx_reg == n_codes_reg) state_next = (n_syms_reg == '0) ? DONE : RUN;
            RUN: begin
                if (sym_hit || wdog_fire)
                    state_next = DONE;
                else if ((bytes_sent_reg >= n_bytes_reg) || last_byte)
                    state_next = DRAIN;
            end
            DRAIN: if (sym_hit || wdog_fire) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            state_reg      <= IDLE;
            n_codes_reg    <= '0;
            n_bytes_reg    <= '0;
            n_syms_reg     <= '0;
            idx_reg        <= '0;
            bytes_sent_reg <= '0;
            sym_cnt_reg    <= '0;
            dec_d_in_reg   <= '0;
            dec_en_in_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                n_codes_reg    <= n_codes;
                n_bytes_reg    <= n_bytes;
                n_syms_reg     <= n_syms;
                idx_reg        <= '0;
                bytes_sent_reg <= '0;
                sym_cnt_reg    <= '0;
                dec_d_in_reg   <= '0;
            end
            if (state_reg == LOAD && idx_reg != n_codes_reg)
                idx_reg <= idx_reg + (TW+1)'(1);
            if (hs) begin
                bytes_sent_reg <= bytes_sent_reg + CW'(1);
                dec_d_in_reg   <= src_data;
            end
            dec_en_in_reg <= hs;
            if (active && dec_en_out)
                sym_cnt_reg <= sym_inc;
        end
    end

    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign dec_new_conf = (state_reg == CLEAR);
    assign dec_ready_in = active;
    assign dec_d_in     = dec_d_in_reg;
    assign dec_en_in    = dec_en_in_reg;
    assign dec_en_conf  = (state_reg == LOAD) && (idx_reg != '0);
    assign tbl_addr     = ((state_reg == LOAD) && (idx_reg < n_codes_reg)) ? idx_reg[TW-1:0] : '0;

    // ROM words pass straight through, gated so the conf buses read 0 outside a valid entry
    logic [W-1:0] tbl_word  [3];
    logic [W-1:0] conf_word [3];

    assign tbl_word[0] = tbl_d;
    assign tbl_word[1] = tbl_h;
    assign tbl_word[2] = tbl_w;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_conf
            assign conf_word[gi] = dec_en_conf ? tbl_word[gi] : '0;
        end
    endgenerate

    assign dec_d_conf = conf_word[0];
    assign dec_h_conf = conf_word[1];
    assign dec_w_conf = conf_word[2];

endmodule

// File: tb/tb_huff_dec_ctrl.sv
// Directed self-checking bench for huff_dec_ctrl; outputs are sampled on the falling edge
// and inputs are changed right after sampling.
module tb_huff_dec_ctrl;

    localparam int W  = 8;
    localparam int TW = 5;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [TW:0]   n_codes;
    logic [CW-1:0] n_bytes;
    logic [CW-1:0] n_syms;
    logic [TW-1:0] tbl_addr;
    logic [W-1:0]  tbl_d, tbl_h, tbl_w;
    logic          src_valid;
    logic [W-1:0]  src_data;
    logic          src_ready;
    logic          dec_new_conf, dec_en_conf;
    logic [W-1:0]  dec_d_conf, dec_h_conf, dec_w_conf;
    logic          dec_ready_in, dec_d_req;
    logic [W-1:0]  dec_d_in;
    logic          dec_en_in, dec_en_out;
    logic          busy, done, err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] rom_d [32];
    logic [W-1:0] rom_h [32];
    logic [W-1:0] rom_w [32];

    logic [19:0] v_src_valid, v_en_out, x_en_in, x_ready, x_done, x_busy, x_rdy_in;
    int   done_at;
    logic err_seen;

    huff_dec_ctrl #(.W(W), .TW(TW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_codes(n_codes), .n_bytes(n_bytes), .n_syms(n_syms),
        .tbl_addr(tbl_addr), .tbl_d(tbl_d), .tbl_h(tbl_h), .tbl_w(tbl_w),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .dec_new_conf(dec_new_conf), .dec_en_conf(dec_en_conf),
        .dec_d_conf(dec_d_conf), .dec_h_conf(dec_h_conf), .dec_w_conf(dec_w_conf),
        .dec_ready_in(dec_ready_in), .dec_d_req(dec_d_req), .dec_d_in(dec_d_in),
        .dec_en_in(dec_en_in), .dec_en_out(dec_en_out),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous table ROM with one cycle of read latency
    always @(posedge clk) begin
        tbl_d <= rom_d[tbl_addr];
        tbl_h <= rom_h[tbl_addr];
        tbl_w <= rom_w[tbl_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_job(input int nc, input int nb, input int ns);
        n_codes = nc[TW:0];
        n_bytes = nb[CW-1:0];
        n_syms  = ns[CW-1:0];
        start   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom_d[i] = 8'h20 + 8'(i);
            rom_h[i] = 8'(i);
            rom_w[i] = 8'h02;
        end
        // job A schedule, bit k = value at the falling edge after rising edge k
        v_src_valid = 20'h00820;
        v_en_out    = 20'h3E380;
        x_en_in     = 20'h01040;
        x_ready     = 20'h00FE0;
        x_done      = 20'h40000;
        x_busy      = 20'h7FFE0;
        x_rdy_in    = 20'h3FFE0;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        n_codes = '0; n_bytes = '0; n_syms = '0;
        src_valid = 1'b0; src_data = '0; dec_d_req = 1'b0; dec_en_out = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tbl_addr", tbl_addr, 0);
        chk("rst_d_in", dec_d_in, 0);
        chk("rst_en_in", dec_en_in, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_new_conf", dec_new_conf, 0);
        chk("rst_en_conf", dec_en_conf, 0);
        chk("rst_d_conf", dec_d_conf, 0);
        chk("rst_ready_in", dec_ready_in, 0);
        start_job(2, 2, 8);
        @(negedge clk);
        chk("rst_over_start", busy, 0);
        rst = 1'b0;
        $display("reset phase: %0d checks", n_vec);

        // job A: two table entries, two bytes with a gap, eight symbols
        dec_d_req = 1'b1;
        src_data  = 8'h11;
        start_job(2, 2, 8);
        @(negedge clk);
        start = 1'b0;
        chk("A_new_conf", dec_new_conf, 1);
        chk("A_busy_clear", busy, 1);
        chk("A_en_conf_clear", dec_en_conf, 0);
        @(negedge clk);
        chk("A_new_conf_off", dec_new_conf, 0);
        chk("A_addr0", tbl_addr, 0);
        chk("A_en_conf_addr0", dec_en_conf, 0);
        chk("A_ready_load", src_ready, 0);
        @(negedge clk);
        chk("A_en_conf_e0", dec_en_conf, 1);
        chk("A_d_conf_e0", dec_d_conf, 8'h20);
        chk("A_h_conf_e0", dec_h_conf, 8'h00);
        chk("A_w_conf_e0", dec_w_conf, 8'h02);
        chk("A_addr1", tbl_addr, 1);
        @(negedge clk);
        chk("A_en_conf_e1", dec_en_conf, 1);
        chk("A_d_conf_e1", dec_d_conf, 8'h21);
        chk("A_h_conf_e1", dec_h_conf, 8'h01);
        chk("A_busy_load", busy, 1);
        for (int k = 5; k < 20; k++) begin
            @(negedge clk);
            if (k == 5) chk("A_en_conf_run", dec_en_conf, 0);
            chk($sformatf("A_en_in_%0d", k), dec_en_in, x_en_in[k]);
            chk($sformatf("A_src_ready_%0d", k), src_ready, x_ready[k]);
            chk($sformatf("A_done_%0d", k), done, x_done[k]);
            chk($sformatf("A_busy_%0d", k), busy, x_busy[k]);
            chk($sformatf("A_ready_in_%0d", k), dec_ready_in, x_rdy_in[k]);
            if (x_en_in[k]) chk($sformatf("A_d_in_%0d", k), dec_d_in, 8'h11);
            if (x_done[k]) chk("A_err", err, 0);
            src_valid  = v_src_valid[k];
            dec_en_out = v_en_out[k];
        end
        $display("job A: 2 entries, 2 bytes, 8 symbols, miscompares so far %0d", n_miss);

        // job B: empty table and zero symbols
        start_job(0, 5, 0);
        @(negedge clk);
        start = 1'b0;
        chk("B_new_conf", dec_new_conf, 1);
        chk("B_ready_clear", src_ready, 0);
        chk("B_done_clear", done, 0);
        @(negedge clk);
        chk("B_done", done, 1);
        chk("B_ready_done", src_ready, 0);
        chk("B_en_conf", dec_en_conf, 0);
        @(negedge clk);
        chk("B_done_off", done, 0);
        chk("B_busy_off", busy, 0);
        $display("job B: empty table, zero symbols, miscompares so far %0d", n_miss);

        // job C: abort at table entry 3 of 16, then a short job
        start_job(16, 1, 4);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("C_addr3", tbl_addr, 3);
        chk("C_en_conf_e2", dec_en_conf, 1);
        chk("C_d_conf_e2", dec_d_conf, 8'h22);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("C_abort_busy", busy, 0);
        chk("C_abort_en_conf", dec_en_conf, 0);
        chk("C_abort_addr", tbl_addr, 0);
        chk("C_abort_d_conf", dec_d_conf, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("C_no_done_%0d", k), done, 0);
            @(negedge clk);
        end
        src_valid = 1'b1;
        src_data  = 8'h5A;
        start_job(1, 1, 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("C2_en_conf", dec_en_conf, 1);
        chk("C2_d_conf", dec_d_conf, 8'h20);
        @(negedge clk);
        chk("C2_ready", src_ready, 1);
        @(negedge clk);
        chk("C2_en_in", dec_en_in, 1);
        chk("C2_d_in", dec_d_in, 8'h5A);
        chk("C2_ready_drain", src_ready, 0);
        dec_en_out = 1'b1;
        @(negedge clk);
        dec_en_out = 1'b0;
        src_valid  = 1'b0;
        chk("C2_done", done, 1);
        chk("C2_err", err, 0);
        @(negedge clk);
        chk("C2_idle", busy, 0);
        $display("job C: abort in table load then restart, miscompares so far %0d", n_miss);

        // job D: reset in RUN acts like abort
        start_job(0, 4, 3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("D_ready_in", dec_ready_in, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("D_rst_busy", busy, 0);
        chk("D_rst_ready_in", dec_ready_in, 0);
        chk("D_rst_done", done, 0);
        $display("job D: reset mid-run, miscompares so far %0d", n_miss);

        // job E: decoder never produces a symbol
        start_job(0, 0, 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        done_at  = 0;
        err_seen = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (done && done_at == 0) begin
                done_at  = n;
                err_seen = err;
            end
        end
`ifdef HDC_TIMEOUT_EN
        chk("E_wdog_cycles", done_at, 255);
        chk("E_wdog_err", err_seen, 1);
        chk("E_idle_after", busy, 0);
`else
        chk("E_no_done", done_at, 0);
        chk("E_still_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("E_abort_busy", busy, 0);
`endif
        $display("job E: stalled decoder, done after %0d cycles (0 = none)", done_at);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/huff_dec_ctrl.md
HUFF_DEC_CTRL -- requirements
Module: huff_dec_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, meaning symbol/code/data width of the Huffman decoder.
REQ-002 SHALL have parameter TW, default 5, meaning table-address width (up to 2^TW code entries).
REQ-003 SHALL have parameter CW, default 16, meaning byte and symbol counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports start  input  1 and abort  input  1: one-cycle job start and job cancel.
REQ-007 SHALL have ports n_codes  input  TW+1, n_bytes  input  CW and n_syms  input  CW, sampled at start: table entries, coded bytes and expected symbols.
REQ-008 SHALL have ports tbl_addr  output  TW, and tbl_d, tbl_h, tbl_w  input  W each: synchronous table ROM with 1-cycle read latency.
REQ-009 SHALL have ports src_valid  input  1, src_data  input  W and src_ready  output  1: coded-byte source handshake.
REQ-010 SHALL have ports dec_new_conf, dec_en_conf  output  1 and dec_d_conf, dec_h_conf, dec_w_conf  output  W: decoder configuration.
REQ-011 SHALL have ports dec_ready_in  output  1, dec_d_req  input  1, dec_d_in  output  W, dec_en_in  output  1 and dec_en_out  input  1: decoder run interface.
REQ-012 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse) and err  output  1 (valid with done).

Function
REQ-013 FSM SHALL have states IDLE, CLEAR, LOAD, RUN, DRAIN and DONE.
REQ-014 IDLE->CLEAR on start; start outside IDLE SHALL be ignored.
REQ-015 CLEAR SHALL last 1 cycle with dec_new_conf=1, then go to LOAD, or to RUN if n_codes=0.
REQ-016 LOAD SHALL drive tbl_addr 0..n_codes-1, one per cycle; each entry SHALL appear on dec_d/h/w_conf with dec_en_conf=1 one cycle after its address.
REQ-017 LOAD->RUN SHALL occur the cycle after the last entry is presented; dec_en_conf SHALL never be high outside LOAD.
REQ-018 RUN and DRAIN SHALL hold dec_ready_in=1.
REQ-019 In RUN, src_ready SHALL be high only when dec_d_req=1 and bytes_sent<n_bytes; a src_valid&src_ready cycle SHALL register src_data to dec_d_in and assert dec_en_in for exactly the following cycle.
REQ-020 RUN->DRAIN when bytes_sent reaches n_bytes; src_ready SHALL stay low afterwards.
REQ-021 sym_cnt SHALL increment on dec_en_out in RUN and DRAIN; reaching n_syms in either state SHALL go to DONE.
REQ-022 n_syms=0 SHALL go from the end of LOAD (or CLEAR) directly to DONE, with no bytes fed.
REQ-023 DONE SHALL last 1 cycle with done=1, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-024 abort in any non-IDLE state SHALL return to IDLE on the next edge with all outputs at reset values and no done pulse.
REQ-025 Counters SHALL saturate and not wrap; dec_en_out in IDLE or DONE SHALL be ignored.

Reset
REQ-026 On rst, state SHALL be IDLE, counters 0, and every output 0 (tbl_addr, dec_d_in and conf buses 0).
REQ-027 rst SHALL take priority over start and abort; rst mid-job SHALL behave like abort.

Configuration
REQ-028 Macro HDC_TIMEOUT_EN SHALL control the watchdog: when defined, parameter TMO (default 255) cycles in RUN/DRAIN without dec_en_out SHALL force DONE with err=1; when undefined, there SHALL be no watchdog and err SHALL be tied 0.

Verification
REQ-029 Reset, start with n_codes=2 ({20,00,2},{21,01,2}) -> dec_new_conf 1 cycle, 2 dec_en_conf cycles with d_conf 0x20 then 0x21, busy=1.
REQ-030 n_bytes=2, n_syms=8, bytes 0x11,0x11, dec_d_req held high -> each byte on dec_d_in with dec_en_in 1 cycle after its handshake; done after the 8th dec_en_out.
REQ-031 src_valid low for 5 cycles mid-RUN -> dec_en_in stays 0 and no byte is dropped or duplicated.
REQ-032 n_codes=0, n_syms=0 -> CLEAR then DONE; done pulse 2 cycles after start, src_ready never high.
REQ-033 abort during LOAD at entry 3 of 16 -> IDLE next cycle, dec_en_conf=0, no done; a new start then completes normally.
REQ-034 HDC_TIMEOUT_EN defined, TMO=255, decoder never asserts dec_en_out -> done=1, err=1 after 255 idle cycles; undefined -> busy stays 1.
